// File: rtl/lif_pkg.sv
// Shared constants and FSM encoding for the LIF neuron scheduler.
package lif_pkg;

  localparam int DEF_N_STAGE   = 3;
  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_MEM_W     = 8;
  localparam int LEAK_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lif_neuron_scheduler_adder_tree.sv
// Combinational population-count adder tree: 2**(N_STAGE+1) one-bit inputs
// reduced pairwise over N_STAGE+1 levels into an (N_STAGE+2)-bit sum.
module adder_tree #(
  parameter int N_STAGE = 3
) (
  input  logic [2**(N_STAGE+1)-1:0] in_bits,
  output logic [N_STAGE+1:0]        sum
);

  localparam int N_IN = 2**(N_STAGE+1);
  localparam int W    = N_STAGE + 2;

  logic [W-1:0] acc [N_IN];

  // NOTE: every variable written in always_comb is assigned on every path
  // before use, so no latch can be inferred.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      acc[i] = W'(in_bits[i]);
    end
    // In-place pairwise reduction; each level only reads slots not yet rewritten.
    for (int l = 0; l <= N_STAGE; l++) begin
      for (int i = 0; i < (N_IN >> (l + 1)); i++) begin
        acc[i] = acc[2*i] + acc[2*i+1];
      end
    end
    sum = acc[0];
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Leaky integrate-and-fire neurons time-multiplexed onto one shared adder tree.
// Optional macro LIF_REFRACTORY_EN adds a one-evaluation refractory period after firing.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int N_STAGE   = DEF_N_STAGE,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int MEM_W     = DEF_MEM_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2**(N_STAGE+1)-1:0]     spikes_in,
  input  logic                          w_we,
  input  logic [$clog2(N_NEURONS)-1:0]  w_addr,
  input  logic [2**(N_STAGE+1)-1:0]     w_data,
  input  logic [MEM_W-1:0]              threshold,
  input  logic [LEAK_W-1:0]             leak_shift,
  output logic                          busy,
  output logic                          done,
  output logic [N_NEURONS-1:0]          spikes_out,
  output logic [N_NEURONS*MEM_W-1:0]    u_out
);

  localparam int N_IN  = 2**(N_STAGE+1);
  localparam int Y_W   = N_STAGE + 2;
  localparam int SUM_W = MEM_W + 1;
  localparam int IDX_W = $clog2(N_NEURONS);

  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N_NEURONS - 1);

  state_t              state_q, state_d;
  idx_t                idx_q;
  logic [N_IN-1:0]     spk_lat;
  logic [MEM_W-1:0]    thr_lat;
  logic [LEAK_W-1:0]   leak_lat;
  logic [N_IN-1:0]     w_mem [N_NEURONS];
  logic [MEM_W-1:0]    u_mem [N_NEURONS];
  logic [N_NEURONS-1:0] fire_acc;
`ifdef LIF_REFRACTORY_EN
  logic [N_NEURONS-1:0] refr_q;
`endif

  logic [N_IN-1:0]      tree_in;
  logic [Y_W-1:0]       y;
  logic [Y_W-1:0]       y_eff;
  logic [MEM_W-1:0]     u_cur;
  logic [SUM_W-1:0]     u_sum;
  logic [MEM_W-1:0]     u_next;
  logic                 refr_cur;
  logic                 fire;
  logic                 last;
  logic [N_NEURONS-1:0] fire_vec;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- shared datapath ----------------
  adder_tree #(.N_STAGE(N_STAGE)) u_tree (
    .in_bits (tree_in),
    .sum     (y)
  );

  always_comb begin
    tree_in = spk_lat & w_mem[idx_q];
    u_cur   = u_mem[idx_q];
`ifdef LIF_REFRACTORY_EN
    refr_cur = refr_q[idx_q];
`else
    refr_cur = 1'b0;
`endif
    y_eff  = refr_cur ? '0 : y;
    // Leak never exceeds u, so the difference stays non-negative; the extra
    // top bit only catches overflow from adding y.
    u_sum  = {1'b0, u_cur} - {1'b0, (u_cur >> leak_lat)} + SUM_W'(y_eff);
    u_next = u_sum[MEM_W] ? '1 : u_sum[MEM_W-1:0];
    fire   = !refr_cur && (u_next >= thr_lat);
    fire_vec        = fire_acc;
    fire_vec[idx_q] = fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      spk_lat    <= '0;
      thr_lat    <= '0;
      leak_lat   <= '0;
      spikes_out <= '0;
      fire_acc   <= '0;
      // NOTE: the weight and membrane arrays are small register files that
      // must read as zero after reset, so they are cleared here explicitly.
      for (int i = 0; i < N_NEURONS; i++) begin
        w_mem[i] <= '0;
        u_mem[i] <= '0;
      end
`ifdef LIF_REFRACTORY_EN
      refr_q <= '0;
`endif
    end else begin
      if (state_q == IDLE) begin
        if (w_we) w_mem[w_addr] <= w_data;
        if (start) begin
          spk_lat  <= spikes_in;
          thr_lat  <= threshold;
          leak_lat <= leak_shift;
          idx_q    <= '0;
        end
      end
      if (state_q == RUN) begin
        u_mem[idx_q] <= fire ? '0 : u_next;
        fire_acc     <= fire_vec;
`ifdef LIF_REFRACTORY_EN
        refr_q[idx_q] <= fire;
`endif
        idx_q <= last ? '0 : idx_q + 1'b1;
        // Spike outputs change only as the timestep completes.
        if (last) spikes_out <= fire_vec;
      end
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_uout
    assign u_out[g*MEM_W +: MEM_W] = u_mem[g];
  end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Self-checking bench for lif_neuron_scheduler: directed scenarios plus random
// timesteps compared against an arithmetic reference model.
module tb_lif_neuron_scheduler;

  localparam int N_STAGE   = 3;
  localparam int N_NEURONS = 4;
  localparam int MEM_W     = 8;
  localparam int N_IN      = 16;
  localparam int U_MAX     = 255;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [N_IN-1:0]      spikes_in;
  logic                 w_we;
  logic [1:0]           w_addr;
  logic [N_IN-1:0]      w_data;
  logic [MEM_W-1:0]     threshold;
  logic [2:0]           leak_shift;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] spikes_out;
  logic [N_NEURONS*MEM_W-1:0] u_out;

  lif_neuron_scheduler #(
    .N_STAGE   (N_STAGE),
    .N_NEURONS (N_NEURONS),
    .MEM_W     (MEM_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .spikes_in  (spikes_in),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .busy       (busy),
    .done       (done),
    .spikes_out (spikes_out),
    .u_out      (u_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mu   [N_NEURONS];
  logic [15:0] mw   [N_NEURONS];
  logic [3:0]  msp;
  bit          mref [N_NEURONS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_NEURONS; k++) begin
      mu[k] = 0; mw[k] = '0; mref[k] = 0;
    end
    msp = '0;
  endtask

  task automatic model_step(input logic [15:0] spk, input int thr, input int ls);
    for (int k = 0; k < N_NEURONS; k++) begin
      int y, un;
      bit f;
      y = $countones(spk & mw[k]);
      if (mref[k]) y = 0;
      un = mu[k] - (mu[k] >> ls) + y;
      if (un > U_MAX) un = U_MAX;
      f = !mref[k] && (un >= thr);
`ifdef LIF_REFRACTORY_EN
      mref[k] = f;
`endif
      mu[k]  = f ? 0 : un;
      msp[k] = f;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < N_NEURONS; k++)
      check($sformatf("%s_u%0d", tag, k), 64'(u_out[k*MEM_W +: MEM_W]), 64'(mu[k]));
    check({tag, "_spikes"}, 64'(spikes_out), 64'(msp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; w_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_w(input int a, input logic [15:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = 2'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
    mw[a] = d;
  endtask

  // One timestep. Optionally writes a weight in the start cycle, and optionally
  // disturbs the latched inputs and pulses start/w_we while running.
  task automatic do_step(input string tag, input logic [15:0] spk, input logic [7:0] thr,
                         input logic [2:0] ls, input bit do_wr, input int wa,
                         input logic [15:0] wd, input bit disturb);
    int ndone, lat;
    @(negedge clk);
    spikes_in = spk; threshold = thr; leak_shift = ls; start = 1'b1;
    if (do_wr) begin
      w_we = 1'b1; w_addr = 2'(wa); w_data = wd;
      mw[wa] = wd;
    end
    model_step(spk, int'(thr), int'(ls));
    ndone = 0; lat = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        start = 1'b0; w_we = 1'b0;
        if (disturb) begin
          spikes_in = ~spk; threshold = ~thr; leak_shift = ~ls;
        end
      end
      if (disturb && cyc == 2) begin
        start = 1'b1; w_we = 1'b1; w_addr = 2'd0; w_data = 16'h0000;
      end
      if (cyc == 3) begin
        start = 1'b0; w_we = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
    end
    check({tag, "_done_cycle"}, 64'(lat), 64'(N_NEURONS + 1));
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    compare_all(tag);
  endtask

  task automatic reset_mid_run(input logic [15:0] spk, input logic [7:0] thr, input logic [2:0] ls);
    int ndone;
    @(negedge clk);
    spikes_in = spk; threshold = thr; leak_shift = ls; start = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2) begin
        check("midrun_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
      end
      if (cyc == 3) reset = 1'b0;
      if (done) ndone++;
    end
    model_reset();
    check("midrun_no_done", 64'(ndone), 64'd0);
    check("midrun_busy", 64'(busy), 64'd0);
    compare_all("midrun");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; spikes_in = '0; w_we = 1'b0; w_addr = '0;
    w_data = '0; threshold = '0; leak_shift = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_spikes", 64'(spikes_out), 64'd0);
    check("rst_u", 64'(u_out), 64'd0);

    // First timestep: u0 = 16, below threshold 20
    write_w(0, 16'hFFFF);
    do_step("ts1", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ts1_u0_16", 64'(u_out[7:0]), 64'd16);
    check("ts1_no_spike", 64'(spikes_out[0]), 64'd0);

    // Second timestep: 16 - 0 + 16 = 32 >= 20 fires and clears
    do_step("ts2", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ts2_spike", 64'(spikes_out[0]), 64'd1);
    check("ts2_u0_zero", 64'(u_out[7:0]), 64'd0);

    // Saturation: after 16 steps u0 = 248; the 17th step gives 263 clamped to
    // 255, which reaches threshold 255 (a wrapped 7 would not).
    do_reset();
    write_w(0, 16'hFFFF);
    for (int s = 0; s < 16; s++)
      do_step($sformatf("sat%0d", s), 16'hFFFF, 8'd255, 3'd7, 0, 0, '0, 0);
    check("sat_u0_248", 64'(u_out[7:0]), 64'd248);
    do_step("sat16", 16'hFFFF, 8'd255, 3'd7, 0, 0, '0, 0);
    check("sat_fire_at_255", 64'(spikes_out[0]), 64'd1);

    // start / w_we during RUN are ignored; latched inputs are unaffected
    do_reset();
    for (int k = 0; k < N_NEURONS; k++) write_w(k, 16'($urandom));
    do_step("ignore", 16'($urandom), 8'd30, 3'd2, 0, 0, '0, 1);
    do_step("ignore_after", 16'hFFFF, 8'd200, 3'd3, 0, 0, '0, 0);

    // Reset at RUN cycle 2, then a fresh timestep
    do_reset();
    for (int k = 0; k < N_NEURONS; k++) write_w(k, 16'hFFFF);
    reset_mid_run(16'hFFFF, 8'd255, 3'd7);
    write_w(1, 16'h00FF);
    do_step("fresh", 16'hFFFF, 8'd255, 3'd7, 0, 0, '0, 0);

    // Randomised timesteps, including write coinciding with start and threshold 0
    do_reset();
    for (int it = 0; it < 25; it++) begin
      bit wr;
      logic [7:0] thr;
      wr  = ($urandom_range(0, 1) == 1);
      thr = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
      do_step($sformatf("rnd%0d", it), 16'($urandom), thr, 3'($urandom_range(0, 7)),
              wr, int'($urandom_range(0, N_NEURONS - 1)), 16'($urandom), 0);
    end

`ifdef LIF_REFRACTORY_EN
    // Fire, refractory step (no input, no spike), then normal integration
    do_reset();
    write_w(0, 16'hFFFF);
    do_step("ref1", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    do_step("ref2", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ref2_fire", 64'(spikes_out[0]), 64'd1);
    do_step("ref3", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ref3_u0_zero", 64'(u_out[7:0]), 64'd0);
    check("ref3_no_spike", 64'(spikes_out[0]), 64'd0);
    do_step("ref4", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ref4_u0_16", 64'(u_out[7:0]), 64'd16);
    do_step("ref5", 16'hFFFF, 8'd20, 3'd7, 0, 0, '0, 0);
    check("ref5_fire", 64'(spikes_out[0]), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
